truth_table_sweeper: RTL and testbench

//  Drives every input vector of an N-input combinational identity pair (lhs/rhs

---
 rtl/truth_table_sweeper_pkg.sv | 15 +
 rtl/truth_table_sweeper_settle_timer.sv | 28 ++
 rtl/truth_table_sweeper.sv | 99 +++++++++
 tb/tb_truth_table_sweeper.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared FSM state encoding for the truth-table sweeper
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int pow2(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// rtl/truth_table_sweeper_settle_timer.sv - settle down-counter; expire marks the last hold cycle
module tts_settle_timer #(
    parameter int SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(SETTLE_CYC - 1);
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all input vectors of a DUT pair and counts lhs/rhs mismatches; STOP_ON_FAIL_EN ends on first mismatch
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            lhs,
    input  logic            rhs,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_fail
);

    localparam int N_VEC = pow2(N_IN);

    state_t state, state_nxt;
    logic   mis;
    logic   last_vec;
    logic   load;
    logic   expire;
    logic   accept;

    assign mis      = lhs ^ rhs;
    assign last_vec = (vec == N_IN'(N_VEC - 1));
    assign accept   = ((state == ST_IDLE) || (state == ST_DONE)) && start;

    tts_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .en     (state == ST_SETTLE),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_SETTLE;
                    load      = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (expire) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
`ifdef STOP_ON_FAIL_EN
                if (last_vec || mis) begin
`else
                if (last_vec) begin
`endif
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_SETTLE;
                    load      = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The vector only advances when the sweep continues, so it never wraps past the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec          <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
        end else if (accept) begin
            vec          <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
        end else if (state == ST_CHECK) begin
            if (mis) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
                if (mismatch_cnt == '0) first_fail <= vec;
            end
            if (state_nxt == ST_SETTLE) vec <= vec + 1'b1;
        end
    end

    assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper (default and STOP_ON_FAIL_EN builds)
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] vec;
    logic       lhs, rhs, busy, done, pass;
    logic [3:0] cnt;
    logic [2:0] ff;
    int         mode = 0;

    logic [1:0] vec2;
    logic       lhs2, rhs2, busy2, done2, pass2;
    logic [2:0] cnt2;
    logic [1:0] ff2;

    // Identity pair X&(Y|Z); mode 1 breaks rhs at vec 5, mode 2 breaks it everywhere.
    always_comb begin
        lhs = vec[2] & (vec[1] | vec[0]);
        case (mode)
            1:       rhs = (vec == 3'd5) ? ~lhs : lhs;
            2:       rhs = ~lhs;
            default: rhs = lhs;
        endcase
    end
    assign lhs2 = vec2[1] & vec2[0];
    assign rhs2 = lhs2;

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lhs(lhs), .rhs(rhs),
        .vec(vec), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(cnt), .first_fail(ff)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE_CYC(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .lhs(lhs2), .rhs(rhs2),
        .vec(vec2), .busy(busy2), .done(done2), .pass(pass2),
        .mismatch_cnt(cnt2), .first_fail(ff2)
    );

    typedef struct {
        int         lat;
        logic [3:0] cnt;
        logic [2:0] ff;
        logic       pass;
        logic [2:0] vec;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor for the 3-input sweeper: vector order/hold and result at each done rise.
    int         t0 = 0, hold = 0;
    logic       busy_q = 1'b0, done_q = 1'b0;
    logic [2:0] lastv = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_q = 1'b0;
            done_q = 1'b0;
        end else begin
            if (busy && !busy_q) begin
                t0 = cyc; lastv = vec; hold = 1;
                check("vec_first", vec, 0);
            end else if (busy) begin
                if (vec !== lastv) begin
                    check("vec_step", vec, 3'(lastv + 3'd1));
                    check("vec_hold", hold, 2);
                    lastv = vec; hold = 1;
                end else begin
                    hold++;
                end
            end
            if (done && !done_q) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("latency", cyc - t0, e.lat);
                    check("mismatch_cnt", cnt, e.cnt);
                    check("first_fail", ff, e.ff);
                    check("pass", pass, e.pass);
                    check("vec_at_done", vec, e.vec);
                    check("busy_at_done", busy, 0);
                end
            end
            busy_q = busy;
            done_q = done;
        end
    end

    // Monitor for the 2-input, 3-cycle-settle sweeper.
    int         t2 = 0, hold2 = 0;
    logic       busy2_q = 1'b0, done2_q = 1'b0;
    logic [1:0] lastv2 = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy2_q = 1'b0;
            done2_q = 1'b0;
        end else begin
            if (busy2 && !busy2_q) begin
                t2 = cyc; lastv2 = vec2; hold2 = 1;
            end else if (busy2) begin
                if (vec2 !== lastv2) begin
                    check("vec2_step", vec2, 2'(lastv2 + 2'd1));
                    check("vec2_hold", hold2, 4);
                    lastv2 = vec2; hold2 = 1;
                end else begin
                    hold2++;
                end
            end
            if (done2 && !done2_q) begin
                if (q2.size() == 0) begin
                    check("unexpected_done2", 1, 0);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    check("latency2", cyc - t2, e.lat);
                    check("mismatch_cnt2", cnt2, e.cnt);
                    check("pass2", pass2, e.pass);
                    check("vec2_at_done", vec2, e.vec);
                end
            end
            busy2_q = busy2;
            done2_q = done2;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == max) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_vec", vec, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_cnt", cnt, 0);
        check("rst_ff", ff, 0);
        rst_n = 1'b1;

        // Abandoned sweep: reset mid-flight after some mismatches have accumulated.
        mode = 2;
        pulse_start();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_vec", vec, 0);
        check("abort_busy", busy, 0);
        check("abort_cnt", cnt, 0);
        check("abort_ff", ff, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", done, 0);

        mode = 0;
        q.push_back('{16, 4'd0, 3'd0, 1'b1, 3'd7});
        pulse_start();
        wait_done("identity", 40);

        mode = 1;
`ifdef STOP_ON_FAIL_EN
        q.push_back('{12, 4'd1, 3'd5, 1'b0, 3'd5});
`else
        q.push_back('{16, 4'd1, 3'd5, 1'b0, 3'd7});
`endif
        pulse_start();
        wait_done("single_fail", 40);

        mode = 2;
`ifdef STOP_ON_FAIL_EN
        q.push_back('{2, 4'd1, 3'd0, 1'b0, 3'd0});
`else
        q.push_back('{16, 4'd8, 3'd0, 1'b0, 3'd7});
`endif
        pulse_start();
        wait_done("all_fail", 40);

        // Restart from DONE clears results; a second start mid-sweep is ignored.
        mode = 0;
        q.push_back('{16, 4'd0, 3'd0, 1'b1, 3'd7});
        pulse_start();
        check("restart_done", done, 0);
        check("restart_cnt", cnt, 0);
        check("restart_busy", busy, 1);
        repeat (5) @(negedge clk);
        pulse_start();
        wait_done("restart", 40);

        q2.push_back('{16, 4'd0, 3'd0, 1'b1, 3'd3});
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        for (int i = 0; i < 40 && !done2; i++) @(negedge clk);
        check("settle3_done", done2, 1);

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        check("queue2_drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
